// File: rtl/s2p16_receiver_if.sv
// Serial link interface between a P2S transmitter side and the S2P receiver.
// The master drives the sample enable and serial line; the slave returns the
// reassembled word, the event pulses and the frame status.
interface s2p16_receiver_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             S_in;
  logic [WIDTH-1:0] P_out;
  logic             valid;
  logic             frame_err;
  logic             busy;
  logic [4:0]       bit_cnt;

  modport master (
    output en,
    output S_in,
    input  P_out,
    input  valid,
    input  frame_err,
    input  busy,
    input  bit_cnt
  );

  modport slave (
    input  en,
    input  S_in,
    output P_out,
    output valid,
    output frame_err,
    output busy,
    output bit_cnt
  );
endinterface

// File: rtl/s2p16_receiver.sv
// Serial-to-parallel receiver: 0 start bit, WIDTH data bits, 1 stop bit.
// A good frame updates P_out and pulses valid; a 0 stop bit pulses frame_err
// and leaves P_out untouched. All state moves only on edges with en=1.
module s2p16_receiver #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  s2p16_receiver_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(WIDTH);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sreg_r,  sreg_s;
  logic [WIDTH-1:0] p_out_r, p_out_s;
  logic [4:0]       cnt_r,   cnt_s;
  logic             valid_r, valid_s;
  logic             ferr_r,  ferr_s;
  logic             busy_r,  busy_s;

  // Insert one received bit into the shift register in the configured order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sreg,
                                                input logic             bit_in);
    if (MSB_FIRST) begin
      shift_in = {sreg[WIDTH-2:0], bit_in};
    end else begin
      shift_in = {bit_in, sreg[WIDTH-1:1]};
    end
  endfunction

  // Next-state and next-output logic; pulses default low so they last one clk.
  always_comb begin
    state_s = state_r;
    sreg_s  = sreg_r;
    p_out_s = p_out_r;
    cnt_s   = cnt_r;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    busy_s  = 1'b0;
    if (bus.en) begin
      case (state_r)
        IDLE: begin
          if (!bus.S_in) begin
            state_s = SHIFT;
            cnt_s   = 5'd0;
          end else begin
            state_s = IDLE;
          end
        end
        SHIFT: begin
          sreg_s = shift_in(sreg_r, bus.S_in);
          cnt_s  = cnt_r + 5'd1;
          if (cnt_s == LAST_CNT) begin
            state_s = STOP;
          end else begin
            state_s = SHIFT;
          end
        end
        STOP: begin
          if (bus.S_in) begin
            p_out_s = sreg_r;
            valid_s = 1'b1;
          end else begin
            ferr_s  = 1'b1;
          end
          state_s = IDLE;
          cnt_s   = 5'd0;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 5'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sreg_r  <= '0;
      p_out_r <= '0;
      cnt_r   <= 5'd0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sreg_r  <= sreg_s;
      p_out_r <= p_out_s;
      cnt_r   <= cnt_s;
      valid_r <= valid_s;
      ferr_r  <= ferr_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.P_out     = p_out_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = ferr_r;
  assign bus.busy      = busy_r;
  assign bus.bit_cnt   = cnt_r;

endmodule
